vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates the raster timing for the VGA output path: hsync, vsync, de and the active-pixel coordinates X/Y.
- Pixel-data blocks (ROM image overlays, pattern sources) consume de/X/Y on pclk and return data_rgb.
- Default timing is 640x480@60 on a 25 MHz pclk.
- All outputs are registered and mutually aligned.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pclk cycles)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level (0 = active-low)

Ports:
- pclk  input  1  pixel clock; single clock domain
- rst  input  1  synchronous reset, active-high
- hsync  output  1  horizontal sync, level per HS_POL
- vsync  output  1  vertical sync, level per VS_POL
- de  output  1  high during active pixels
- X  output  10  active-pixel column 0..H_ACTIVE-1; 0 when de=0
- Y  output  10  active-pixel row 0..V_ACTIVE-1; 0 when de=0
- line_start  output  1  one-cycle pulse on the first active pixel of each line
- frame_start  output  1  one-cycle pulse on pixel (0,0) of each frame

Behaviour:
- Interface: one clock (pclk); reset is synchronous and active-high (rst).
- Derived values:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800).
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525).
- Internal counters h_cnt and v_cnt, each 10 bits (sized by $clog2 of the totals if larger).
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - On that wrap, v_cnt increments; it wraps 0 after V_TOTAL-1.
  - At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, both go to 0 on the same edge.
- Region order within a line and within a frame: active, front porch, sync, back porch.
  - Active: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC (default 656..751).
  - vsync asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC (default 490..491). vsync spans whole lines and changes only together with h_cnt wrap.
- Latency: outputs are registered from the current counter values, so they lag the counters by exactly 1 pclk. hsync, vsync, de, X, Y and the pulses all refer to the same counter value in the same cycle.
- X = h_cnt and Y = v_cnt while active; both forced to 0 outside active.
- line_start = 1 when h_cnt=0 and v_cnt<V_ACTIVE.
- frame_start = 1 when h_cnt=0 and v_cnt=0, coincident with that line's line_start.
- Reset state, on any edge with rst=1, including mid-frame:
  - h_cnt=v_cnt=0.
  - de=0, X=Y=0, line_start=frame_start=0.
  - hsync=!HS_POL, vsync=!VS_POL.
- After reset: on the first edge with rst=0, outputs present counter (0,0): de=1, X=0, Y=0, frame_start=1, line_start=1. Timing restarts cleanly with no partial sync pulse.
- Per-frame counts: exactly H_ACTIVE*V_ACTIVE de-high cycles (307200 at defaults); H_TOTAL*V_TOTAL cycles frame period (420000).
- No back-pressure and no enable input; the generator free-runs.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- With the macro defined:
  - Adds output pattern_rgb [15:0] in RGB565, registered and aligned with de.
  - 8 vertical colour bars, each H_ACTIVE/8 pixels wide (80 by default), selected by the column value.
  - Bar order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
  - pattern_rgb = 0 when de=0 and in reset.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset release: hold rst=1 for 5 cycles, then release -> in reset, de=0, hsync=vsync=1. First cycle after release: de=1, X=0, Y=0, frame_start=1, line_start=1.
- Line timing: run one line -> de high for exactly 640 consecutive cycles (X 0..639). hsync low for exactly 96 cycles, starting 656 cycles after line_start. line_start period is 800 cycles.
- Frame timing: run 2 full frames -> frame_start period 420000 cycles. 307200 de-high cycles per frame. vsync low for 1600 cycles starting 490*800 cycles after frame_start. Last active pixel is X=639, Y=479.
- Wrap corner: observe the transition from (h_cnt 799, v_cnt 524) -> next outputs show X=0, Y=0, frame_start=1, with no extra or missing line.
- Mid-frame reset: assert rst for 1 cycle at Y=200, X=300 -> next cycle shows reset values. The cycle after that shows frame_start=1, X=0, Y=0, and vsync is not asserted.
- VGA_TEST_PATTERN_EN build: sample X=0, 79, 80, 639 on any active line -> pattern_rgb = FFFF, FFFF, FFE0, 0000. Outside active (de=0) -> pattern_rgb = 0000.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered, mutually aligned sync/de/X/Y/pulse outputs.
// Optional colour-bar source on pattern_rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic       pclk,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] X,
  output logic [9:0] Y,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [15:0] pattern_rgb
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] h_cnt_reg, h_cnt_next;
  logic [VW-1:0] v_cnt_reg, v_cnt_next;
  logic          active, hs_active, vs_active;
  logic          line_start_next, frame_start_next;
  logic [9:0]    x_next, y_next;

  always_comb begin
    h_cnt_next = h_cnt_reg + HW'(1);
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      if (v_cnt_reg == V_LAST) begin
        v_cnt_next = '0;
      end else begin
        v_cnt_next = v_cnt_reg + VW'(1);
      end
    end
  end

  // All decode is from the current counter value so every output lags the counters by one pclk.
  always_comb begin
    active           = (h_cnt_reg < H_ACT_END) && (v_cnt_reg < V_ACT_END);
    hs_active        = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
    vs_active        = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);
    line_start_next  = (h_cnt_reg == '0) && (v_cnt_reg < V_ACT_END);
    frame_start_next = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    x_next           = '0;
    y_next           = '0;
    if (active) begin
      x_next = h_cnt_reg[9:0];
      y_next = v_cnt_reg[9:0];
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      de          <= 1'b0;
      X           <= '0;
      Y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
      hsync       <= hs_active ? HS_POL : ~HS_POL;
      vsync       <= vs_active ? VS_POL : ~VS_POL;
      de          <= active;
      X           <= x_next;
      Y           <= y_next;
      line_start  <= line_start_next;
      frame_start <= frame_start_next;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic [6:0]  bar_ge;
  logic [2:0]  bar_idx;
  logic [15:0] bar_rgb;
  logic [15:0] pattern_next;

  // Bar index is the number of bar boundaries already passed; avoids a divider.
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_bar
      localparam logic [HW-1:0] BOUND = HW'(BAR_W * (gi + 1));
      assign bar_ge[gi] = (h_cnt_reg >= BOUND);
    end
  endgenerate

  always_comb begin
    bar_idx = 3'($countones(bar_ge));
    case (bar_idx)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
    pattern_next = active ? bar_rgb : 16'h0000;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pattern_rgb <= 16'h0000;
    end else begin
      pattern_rgb <= pattern_next;
    end
  end
`endif

endmodule
